mu0_ram_arbiter: RTL and testbench
==================================

# mu0_ram_arbiter

Two-port arbiter sharing a single `RAM_16x4096_delay1` instance between two MU0-side bus masters, e.g. the CPU decoder and a loader/debug port. Each cycle it grants at most one request, drives the RAM with the winning command, and steers the one-cycle-late read data back to the master that issued the read. Conflicts are resolved round-robin, or fixed-priority when selected.

## Interface
- `ADDR_W`, 12, word address width (4096 words)
- `DATA_W`, 16, data width
- `FIXED_PRIO`, 0, 1 = master 0 always wins conflicts; 0 = round-robin
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset (asserted when 0)
- `m0_address`, `m1_address`  in  ADDR_W  request address
- `m0_read`, `m1_read`  in  1  read request
- `m0_write`, `m1_write`  in  1  write request
- `m0_writedata`, `m1_writedata`  in  DATA_W  write data
- `m0_waitrequest`, `m1_waitrequest`  out  1  1 = request not accepted this cycle; hold it
- `m0_readdata`, `m1_readdata`  out  DATA_W  returned read data
- `m0_readdatavalid`, `m1_readdatavalid`  out  1  readdata valid this cycle
- `ram_address`  out  ADDR_W, `ram_read`  out  1, `ram_write`  out  1, `ram_writedata`  out  DATA_W  to RAM
- `ram_readdata`  in  DATA_W  from RAM, valid the cycle after `ram_read` is sampled

## Operation
- Master requests when `read|write` = 1. Request is accepted on a rising edge where it is asserted and its `waitrequest` = 0; master must hold address/data/command stable while `waitrequest` = 1.
- Grant (combinational from requests + `last` register):
  - one requester → granted;
  - both → `FIXED_PRIO`=1: m0; else the master that is not `last`;
  - none → no grant, `ram_read`=`ram_write`=0, `ram_address`=0, `ram_writedata`=0.
- Granted master's command passes through to `ram_*` in the same cycle; loser sees `waitrequest`=1. Non-requesting master sees `waitrequest`=0.
- `last` updates to the granted index on every accepted request; unchanged when idle.
- `read` and `write` both high from one master: illegal; write forwarded, read dropped, no readdatavalid generated.
- Read return: on accepted read, register `pend_valid`=1, `pend_owner`=index. Next cycle `mX_readdatavalid`=1 for owner only, `mX_readdata`=`ram_readdata`. Both masters' `readdata` buses carry `ram_readdata`; only valid is steered.
- Back-to-back reads (same or alternating masters) accepted every cycle; one outstanding return per cycle, no stall needed.

## Timing
- Reset (`rst`=0 at edge): `last`=1 (m0 wins first RR conflict), `pend_valid`=0. While `rst`=0: both `waitrequest`=1, `ram_read`=`ram_write`=0, both `readdatavalid`=0.
- Reset mid-read: pending return discarded; no `readdatavalid` in the cycle after reset.
- Accept-to-RAM latency 0 cycles; read latency accept→`readdatavalid` exactly 1 cycle.
- Write completes on the accepting edge; no response.
- Round-robin with both requesting continuously: grants alternate m0,m1,m0,...; max wait 1 cycle.
- Simultaneous write by m0 and read by m1 at same address: grant order decides; read sees old data if it wins, new data if it follows the write.

## Structure
- Package `mu0_mem_pkg`: `ADDR_W`/`DATA_W` constants, `typedef logic [ADDR_W-1:0] mem_addr_t`, `typedef logic [DATA_W-1:0] mem_data_t`, `typedef enum logic {M0, M1} master_t`.
- Sub-module `rr_arbiter2`: inputs two requests, `last`, `FIXED_PRIO`; outputs one-hot grant. Registers (`last`, `pend_valid`, `pend_owner`) stay in top.

## Test plan
- Reset: hold `rst`=0 two cycles with both masters reading → both `waitrequest`=1, `ram_read`=0, no `readdatavalid`.
- Single master: m0 reads addr 0x005 (RAM preloaded 0x1234) → `ram_read`=1 same cycle, next cycle `m0_readdatavalid`=1, `m0_readdata`=0x1234, `m1_readdatavalid`=0.
- Conflict RR: both read continuously after reset (m0→0x010, m1→0x020) → grants m0,m1,m0,m1; valids alternate, data matches owner's address.
- Fixed priority (`FIXED_PRIO`=1): both request 4 cycles → m0 granted all 4, `m1_waitrequest`=1 throughout; m1 granted cycle after m0 drops.
- Write/read ordering: m0 writes 0xBEEF to 0x100 while m1 reads 0x100, m0 granted first → m1 read returns 0xBEEF.
- Reset mid-read: m1 read accepted, `rst`=0 next edge → no `m1_readdatavalid`; post-reset `last`=1 (m0 wins next conflict).

Source files
------------

// File: rtl/mu0_mem_pkg.sv
// Shared types for the MU0 memory subsystem: word/address widths and master identifiers.
package mu0_mem_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  typedef logic [ADDR_W-1:0] mem_addr_t;
  typedef logic [DATA_W-1:0] mem_data_t;

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_t;

  // Index of the master holding a one-hot grant (M0 when no grant is asserted).
  function automatic master_t grant_owner(input logic [1:0] grant);
    return grant[1] ? M1 : M0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: round-robin against the last granted master, or fixed priority
// to master 0 when FIXED_PRIO is set. Purely combinational; the caller owns 'last'.
module rr_arbiter2
  import mu0_mem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] i_req,
  input  master_t    i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case (i_req)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      2'b11: begin
        // On conflict the master that did not win last time goes next.
        if (FIXED_PRIO || (i_last == M1)) o_grant = 2'b01;
        else                              o_grant = 2'b10;
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mu0_ram_arbiter.sv
// Shares one single-port RAM with one-cycle read latency between two MU0 bus masters.
// Command path is combinational; only the arbitration pointer and read-return owner are stored.
module mu0_ram_arbiter #(
  parameter int unsigned ADDR_W     = mu0_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W     = mu0_mem_pkg::DATA_W,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  import mu0_mem_pkg::master_t;
  import mu0_mem_pkg::M0;
  import mu0_mem_pkg::M1;
  import mu0_mem_pkg::grant_owner;

  logic       w_req0;
  logic       w_req1;
  logic [1:0] w_grant;
  master_t    r_last;
  master_t    r_pend_owner;
  logic       r_pend_valid;

  // Requests are masked while reset is held so nothing reaches the RAM.
  assign w_req0 = rst & (m0_read | m0_write);
  assign w_req1 = rst & (m1_read | m1_write);

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .i_req   ({w_req1, w_req0}),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  // Winning command straight to the RAM; a read paired with a write is dropped.
  always_comb begin
    ram_address   = '0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    ram_writedata = '0;
    if (w_grant[0]) begin
      ram_address   = m0_address;
      ram_write     = m0_write;
      ram_read      = m0_read & ~m0_write;
      ram_writedata = m0_writedata;
    end else if (w_grant[1]) begin
      ram_address   = m1_address;
      ram_write     = m1_write;
      ram_read      = m1_read & ~m1_write;
      ram_writedata = m1_writedata;
    end
  end

  assign m0_waitrequest = ~rst | (w_req0 & ~w_grant[0]);
  assign m1_waitrequest = ~rst | (w_req1 & ~w_grant[1]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last       <= M1;
      r_pend_valid <= 1'b0;
      r_pend_owner <= M0;
    end else begin
      if (|w_grant) r_last <= grant_owner(w_grant);
      r_pend_valid <= ram_read;
      if (ram_read) r_pend_owner <= grant_owner(w_grant);
    end
  end

  // Read data is broadcast; only the valid strobe is steered to the issuing master.
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rst & r_pend_valid & (r_pend_owner == M0);
  assign m1_readdatavalid = rst & r_pend_valid & (r_pend_owner == M1);

endmodule

// File: tb/tb_mu0_ram_arbiter.sv
// Bench for mu0_ram_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of grant, RAM command and read return.
module tb_mu0_ram_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;

  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read, m1_read, m0_write, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] ram_address;
  logic          ram_read, ram_write;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata;

  logic [AW-1:0] f_m0_address, f_m1_address;
  logic          f_m0_read, f_m1_read;
  logic          f_m0_waitrequest, f_m1_waitrequest;
  logic [DW-1:0] f_m0_readdata, f_m1_readdata;
  logic          f_m0_readdatavalid, f_m1_readdatavalid;
  logic [AW-1:0] f_ram_address;
  logic          f_ram_read, f_ram_write;
  logic [DW-1:0] f_ram_writedata;

  always #5 clk = ~clk;

  mu0_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  mu0_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .m0_address(f_m0_address), .m0_read(f_m0_read), .m0_write(1'b0),
    .m0_writedata(16'h00A5), .m0_waitrequest(f_m0_waitrequest),
    .m0_readdata(f_m0_readdata), .m0_readdatavalid(f_m0_readdatavalid),
    .m1_address(f_m1_address), .m1_read(f_m1_read), .m1_write(1'b0),
    .m1_writedata(16'h005A), .m1_waitrequest(f_m1_waitrequest),
    .m1_readdata(f_m1_readdata), .m1_readdatavalid(f_m1_readdatavalid),
    .ram_address(f_ram_address), .ram_read(f_ram_read), .ram_write(f_ram_write),
    .ram_writedata(f_ram_writedata), .ram_readdata(16'h0000)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return 16'h1234;
    return 16'(i * 7 + 3);
  endfunction

  // RAM with one-cycle read latency, preloaded from init_val
  logic [DW-1:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (ram_write) mem[ram_address] <= ram_writedata;
      if (ram_read)  ram_readdata     <= mem[ram_address];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_last;
  bit            m_pend;
  int            m_owner;
  logic [DW-1:0] m_pdata;
  logic [DW-1:0] shadow [4096];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs for the current cycle, then advance the model across the coming edge.
  task automatic model_check();
    bit r0, r1;
    int g;
    logic er, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (rst !== 1'b1) begin
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_ram_read", ram_read, 0);
      chk("rst_ram_write", ram_write, 0);
      chk("rst_rdv0", m0_readdatavalid, 0);
      chk("rst_rdv1", m1_readdatavalid, 0);
      m_last = 1;
      m_pend = 1'b0;
      return;
    end
    chk("rdv0", m0_readdatavalid, 32'(m_pend && m_owner == 0));
    chk("rdv1", m1_readdatavalid, 32'(m_pend && m_owner == 1));
    if (m_pend) begin
      chk("rdata0", m0_readdata, m_pdata);
      chk("rdata1", m1_readdata, m_pdata);
    end
    g = -1;
    if (r0 && r1)  g = (m_last == 0) ? 1 : 0;
    else if (r0)   g = 0;
    else if (r1)   g = 1;
    er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
    if (g == 0) begin
      ew = m0_write; er = m0_read & ~m0_write; ea = m0_address; ed = m0_writedata;
    end else if (g == 1) begin
      ew = m1_write; er = m1_read & ~m1_write; ea = m1_address; ed = m1_writedata;
    end
    chk("ram_read", ram_read, er);
    chk("ram_write", ram_write, ew);
    chk("ram_address", ram_address, ea);
    chk("ram_writedata", ram_writedata, ed);
    chk("wait0", m0_waitrequest, 32'(r0 && g != 0));
    chk("wait1", m1_waitrequest, 32'(r1 && g != 1));
    m_pend = er;
    if (er) begin
      m_owner = g;
      m_pdata = shadow[ea];
    end
    if (ew) shadow[ea] = ed;
    if (g >= 0) m_last = g;
  endtask

  task automatic half();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_master(input int m);
    int            r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rd, wr;
    r  = $urandom_range(0, 9);
    a  = AW'($urandom_range(0, 15));
    d  = DW'($urandom);
    rd = (r >= 4 && r <= 6) || r == 9;
    wr = (r >= 7);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    end
  endtask

  bit h0, h1;

  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
    m_last = 1; m_pend = 1'b0; m_owner = 0; m_pdata = '0;
    rst = 1'b0;
    m0_address = '0; m1_address = '0; m0_read = 1'b0; m1_read = 1'b0;
    m0_write = 1'b0; m1_write = 1'b0; m0_writedata = '0; m1_writedata = '0;
    f_m0_address = '0; f_m1_address = '0; f_m0_read = 1'b0; f_m1_read = 1'b0;
    adv();

    // Reset held two cycles with both masters reading
    m0_read = 1'b1; m0_address = 12'h005;
    m1_read = 1'b1; m1_address = 12'h020;
    repeat (2) begin
      half();
      chk("lit_rst_ram_read", ram_read, 0);
      chk("lit_rst_wait0", m0_waitrequest, 1);
      adv();
    end

    // Round-robin conflict straight out of reset: m0 first, then alternate
    rst = 1'b1; m0_address = 12'h010;
    for (int k = 0; k < 5; k++) begin
      half();
      chk("lit_rr_wait0", m0_waitrequest, 32'(k % 2 == 1));
      chk("lit_rr_addr", ram_address, (k % 2 == 0) ? 32'h010 : 32'h020);
      if (k >= 1) begin
        chk("lit_rr_rdv0", m0_readdatavalid, 32'(k % 2 == 1));
        chk("lit_rr_rdv1", m1_readdatavalid, 32'(k % 2 == 0));
        chk("lit_rr_rdata", m0_readdata, (k % 2 == 1) ? 32'h0073 : 32'h00E3);
      end
      adv();
    end
    m0_read = 1'b0; m1_read = 1'b0;
    half(); adv();

    // Single master read of a preloaded word
    m0_read = 1'b1; m0_address = 12'h005;
    half();
    chk("lit_single_ram_read", ram_read, 1);
    chk("lit_single_wait0", m0_waitrequest, 0);
    adv();
    m0_read = 1'b0;
    half();
    chk("lit_single_rdv0", m0_readdatavalid, 1);
    chk("lit_single_rdata", m0_readdata, 32'h1234);
    chk("lit_single_rdv1", m1_readdatavalid, 0);
    adv();

    // Reset while an m1 read is outstanding
    m1_read = 1'b1; m1_address = 12'h020;
    half(); adv();
    rst = 1'b0; m1_read = 1'b0;
    half();
    chk("lit_midrst_rdv1", m1_readdatavalid, 0);
    adv();
    rst = 1'b1;

    // Write then read of the same word; m0 wins because reset left last=m1
    m0_write = 1'b1; m0_address = 12'h100; m0_writedata = 16'hBEEF;
    m1_read = 1'b1; m1_address = 12'h100;
    half();
    chk("lit_wr_ram_write", ram_write, 1);
    chk("lit_wr_wait1", m1_waitrequest, 1);
    chk("lit_wr_rdv1", m1_readdatavalid, 0);
    adv();
    m0_write = 1'b0;
    half();
    chk("lit_wr_ram_read", ram_read, 1);
    adv();
    m1_read = 1'b0;
    half();
    chk("lit_wr_rdv1b", m1_readdatavalid, 1);
    chk("lit_wr_rdata", m1_readdata, 32'hBEEF);
    adv();

    // Fixed-priority instance: m0 keeps winning, m1 gets in once m0 stops
    f_m0_read = 1'b1; f_m0_address = 12'h011;
    f_m1_read = 1'b1; f_m1_address = 12'h022;
    for (int k = 0; k < 4; k++) begin
      half();
      chk("fp_wait1", f_m1_waitrequest, 1);
      chk("fp_wait0", f_m0_waitrequest, 0);
      chk("fp_addr", f_ram_address, 32'h011);
      chk("fp_wdata", f_ram_writedata, 32'h00A5);
      chk("fp_rdv0", f_m0_readdatavalid, 32'(k >= 1));
      chk("fp_rdv1", f_m1_readdatavalid, 0);
      adv();
    end
    f_m0_read = 1'b0;
    half();
    chk("fp_m1_wait", f_m1_waitrequest, 0);
    chk("fp_m1_addr", f_ram_address, 32'h022);
    chk("fp_m1_read", f_ram_read, 1);
    chk("fp_m1_wdata", f_ram_writedata, 32'h005A);
    chk("fp_ram_write", f_ram_write, 0);
    chk("fp_rdata", f_m0_readdata | f_m1_readdata, 0);
    adv();
    f_m1_read = 1'b0;

    // Random traffic; masters hold a request until it is accepted
    for (int c = 0; c < 4000; c++) begin
      half();
      h0 = (m0_read | m0_write) && m0_waitrequest;
      h1 = (m1_read | m1_write) && m1_waitrequest;
      adv();
      rst = ($urandom_range(0, 149) != 0);
      if (!h0) rand_master(0);
      if (!h1) rand_master(1);
    end
    half();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
